conv_result_streamer: RTL and testbench
=======================================

# conv_result_streamer

Parallel-to-serial converter for the convolution output path. It accepts one complete flattened result frame (all output channels, all result positions) in a single `in_valid` cycle and emits it one element per accepted beat on a valid/ready stream. Each element carries its channel/row/column coordinates and a last-of-frame flag. It sits between the convolution top level and the next layer (pooling/activation), which consume one float16 element at a time.

## Interface
- `data_width`, 16: bits per element (float16).
- `output_channel`, 1: channels per frame.
- `result_width`, 2: columns per channel.
- `result_length`, 2: rows per channel.
- `num_elem`, derived: `output_channel*result_length*result_width`.
- `cnt_w`, derived: `max(1, $clog2(num_elem))`.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: frame presented on `result`.
- `in_ready`  out  1: block can capture a frame this cycle.
- `result`  in  [0:num_elem*data_width-1]: flattened frame. Element i is `result[i*data_width +: data_width]`, with i = ch*result_length*result_width + row*result_width + col.
- `out_data`  out  data_width: current element.
- `out_valid`  out  1: `out_data` and coordinates are valid.
- `out_ready`  in  1: downstream accepts the beat.
- `out_last`  out  1: current element is i = num_elem-1.
- `out_ch`, `out_row`, `out_col`  out  clog2-sized, min 1: coordinates of the current element.

## Operation
- FSM has two states: IDLE and STREAM.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`, capture `result` into the frame register, clear the index to 0, and go to STREAM.
- STREAM:
  - `out_valid`=1 and `out_data` = element[index].
  - On a beat (`out_valid && out_ready`), the index increments. The ch/row/col counters advance col→row→ch with wrap at result_width/result_length.
  - A beat with `out_last`=1 returns the FSM to IDLE and resets the index to 0.
- Without `CONV_STREAM_PINGPONG_EN`, `in_ready`=0 throughout STREAM and `in_valid` is ignored there. No capture and no error.
- While `out_valid && !out_ready`: `out_data`, coordinates and `out_last` hold stable.
- `out_valid` does not drop before the beat completes.
- Counters are sized by `cnt_w`/clog2; they never use `data_width` for indexing.
- Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `out_ch`/`out_row`/`out_col`=0, FSM=IDLE, frame register=0.
- `in_ready` is combinational from registered state only. It has no path from `in_valid` or `out_ready`.
- Reset asserted mid-frame: the partial frame is discarded, and all outputs return to reset values asynchronously.

## Timing
- Capture at edge N puts element 0 on the outputs with `out_valid`=1 from cycle N+1.
- Back-to-back `out_ready`=1 gives one element per cycle. The last beat is in cycle N+num_elem.
- Without the macro, `in_ready` rises the cycle after the last beat. Minimum frame period is num_elem+1 cycles.
- `num_elem`=1: element 0 is both first and last, so `out_last`=1 on the only beat.

## Configuration
- `CONV_STREAM_PINGPONG_EN` defined: adds a shadow frame register plus a full flag.
  - `in_ready` = !shadow_full, in both states.
  - A capture in STREAM fills the shadow.
  - On the last beat with shadow_full, the shadow moves to the active register, the index resets, the state stays STREAM, and shadow_full clears. Element 0 of the new frame appears the next cycle, so there is no bubble.
  - A capture in the same cycle as that last beat, with the shadow empty, goes straight to the active register.
- Macro undefined: single buffer, behaviour as in Operation.

## Structure
- Shared package `conv_pkg`: FSM state enum (`CS_IDLE`, `CS_STREAM`), a `clog2_min1` helper function, and the float16 width constant.
- One sub-module, `conv_stream_index`: a nested ch/row/col counter with `clr`/`inc` inputs and `last` output. It is reused later by the pooling reader.

## Test plan
Configuration for all tests: data_width=16, output_channel=2, result 2×2 (num_elem=8), frame elements 0x0001..0x0008.
- Single frame, `out_ready`=1 constantly → 8 beats on cycles 1..8 after capture. `out_data` runs 0x0001..0x0008. ch/row/col go (0,0,0),(0,0,1),(0,1,0),(0,1,1),(1,0,0)…; `out_last` is high only on 0x0008. `in_ready` returns to 1 one cycle later.
- `out_ready` toggling 1,0,0,1… → each element is held stable during stalls. Exactly 8 beats, no duplicates and no skips.
- `in_valid` with frame 0x00A1..0x00A8 during STREAM, macro off → ignored. Only 0x0001..0x0008 is emitted.
- Reset pulse after the 3rd beat → outputs are zero immediately and `in_ready`=1 after release. A new frame streams from element 0.
- Macro on: second frame captured mid-stream, `out_ready`=1 → 16 consecutive beats with no gap. `out_last` is high on beats 8 and 16.
- Macro on: a third frame offered while the shadow is full → `in_ready`=0 and the frame is not captured.

Source files
------------

// File: rtl/conv_pkg.sv
// ============================================================================
// Module   : conv_pkg
// Purpose  : Shared types and helpers for the convolution output path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_pkg;

    // Width of one float16 result element
    localparam int FP16_W = 16;

    // Streamer FSM states
    typedef enum logic [0:0] {
        CS_IDLE   = 1'b0,
        CS_STREAM = 1'b1
    } cs_state_t;

    // $clog2 that never returns zero, so single-entry counters keep one bit
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_stream_index.sv
// ============================================================================
// Module   : conv_stream_index
// Purpose  : Nested channel/row/column counter. The column advances first,
//            then the row, then the channel; everything wraps after the final
//            element. Also used by the pooling reader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_stream_index
    import conv_pkg::*;
#(
    parameter int N_CH  = 1,
    parameter int N_ROW = 2,
    parameter int N_COL = 2,
    parameter int CH_W  = clog2_min1(N_CH),
    parameter int ROW_W = clog2_min1(N_ROW),
    parameter int COL_W = clog2_min1(N_COL)
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CH_W-1:0]  ch,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);

    localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(N_CH - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(N_ROW - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(N_COL - 1);

    // Coordinate counters; clear wins over increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch  <= '0;
            row <= '0;
            col <= '0;
        end else if (clr) begin
            ch  <= '0;
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (col == COL_MAX) begin
                col <= '0;
                if (row == ROW_MAX) begin
                    row <= '0;
                    ch  <= (ch == CH_MAX) ? '0 : ch + 1'b1;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign last = (ch == CH_MAX) && (row == ROW_MAX) && (col == COL_MAX);

endmodule

`default_nettype wire

// File: rtl/conv_result_streamer.sv
// ============================================================================
// Module   : conv_result_streamer
// Purpose  : Captures one flattened convolution result frame and streams it
//            out one float16 element per valid/ready beat, tagged with its
//            channel/row/column and a last-of-frame flag.
// Options  : CONV_STREAM_PINGPONG_EN - adds a shadow frame buffer so the next
//            frame can be accepted while the current one streams.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_result_streamer
    import conv_pkg::*;
#(
    parameter  int data_width     = FP16_W,
    parameter  int output_channel = 1,
    parameter  int result_width   = 2,
    parameter  int result_length  = 2,
    localparam int num_elem       = output_channel * result_length * result_width,
    localparam int cnt_w          = clog2_min1(num_elem),
    localparam int ch_w           = clog2_min1(output_channel),
    localparam int row_w          = clog2_min1(result_length),
    localparam int col_w          = clog2_min1(result_width)
)(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [0:num_elem*data_width-1]   result,
    output logic [data_width-1:0]            out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic [ch_w-1:0]                  out_ch,
    output logic [row_w-1:0]                 out_row,
    output logic [col_w-1:0]                 out_col
);

    cs_state_t                         state;
    logic [0:num_elem*data_width-1]    frame;
    logic [cnt_w-1:0]                  idx;
    logic                              idx_last;
    logic                              capture;
    logic                              beat;
    logic                              beat_last;
    logic                              idx_clr;

`ifdef CONV_STREAM_PINGPONG_EN
    logic [0:num_elem*data_width-1]    shadow;
    logic                              shadow_full;

    // Ready whenever there is somewhere to put a frame
    assign in_ready = !shadow_full;
`else
    // Single buffer: only accept while nothing is streaming
    assign in_ready = (state == CS_IDLE);
`endif

    assign capture   = in_valid && in_ready;
    assign out_valid = (state == CS_STREAM);
    assign beat      = out_valid && out_ready;
    assign beat_last = beat && idx_last;
    assign out_last  = out_valid && idx_last;
    assign out_data  = frame[int'(idx)*data_width +: data_width];

    // Restart coordinates on a fresh capture or at the end of every frame
    assign idx_clr = (capture && (state == CS_IDLE)) || beat_last;

    conv_stream_index #(
        .N_CH  (output_channel),
        .N_ROW (result_length),
        .N_COL (result_width)
    ) u_index (
        .clk   (clk),
        .reset (reset),
        .clr   (idx_clr),
        .inc   (beat),
        .ch    (out_ch),
        .row   (out_row),
        .col   (out_col),
        .last  (idx_last)
    );

    // Frame capture, element index and IDLE/STREAM sequencing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= CS_IDLE;
            frame       <= '0;
            idx         <= '0;
`ifdef CONV_STREAM_PINGPONG_EN
            shadow      <= '0;
            shadow_full <= 1'b0;
`endif
        end else begin
            case (state)
                CS_IDLE: begin
                    if (capture) begin
                        frame <= result;
                        idx   <= '0;
                        state <= CS_STREAM;
                    end
                end
                CS_STREAM: begin
                    if (beat) begin
                        if (idx_last) begin
                            idx <= '0;
`ifdef CONV_STREAM_PINGPONG_EN
                            if (shadow_full) begin
                                frame       <= shadow;
                                shadow_full <= 1'b0;
                            end else if (capture) begin
                                frame <= result;
                            end else begin
                                state <= CS_IDLE;
                            end
`else
                            state <= CS_IDLE;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
`ifdef CONV_STREAM_PINGPONG_EN
                    // A frame arriving mid-stream waits in the shadow buffer
                    if (capture && !beat_last) begin
                        shadow      <= result;
                        shadow_full <= 1'b1;
                    end
`endif
                end
                default: state <= CS_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_conv_result_streamer.sv
// ============================================================================
// Module   : tb_conv_result_streamer
// Purpose  : Self-checking bench for conv_result_streamer (2 channels, 2x2).
// Options  : CONV_STREAM_PINGPONG_EN - enables the double-buffer sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_result_streamer;
    import conv_pkg::*;

    localparam int DW  = 16;
    localparam int OC  = 2;
    localparam int RW  = 2;
    localparam int RL  = 2;
    localparam int NE  = OC * RW * RL;
    localparam int CHW = clog2_min1(OC);
    localparam int RWW = clog2_min1(RL);
    localparam int CLW = clog2_min1(RW);
`ifdef CONV_STREAM_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    typedef logic [0:NE*DW-1] frame_t;

    typedef struct {
        logic        rdy;
        logic        vld;
        logic [15:0] data;
        logic        last;
        int          ch;
        int          row;
        int          col;
        logic        irdy;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    frame_t         result = '0;
    logic [DW-1:0]  out_data;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           out_last;
    logic [CHW-1:0] out_ch;
    logic [RWW-1:0] out_row;
    logic [CLW-1:0] out_col;

    int checks = 0;
    int errors = 0;
    vec_t vt[10];

    conv_result_streamer #(
        .data_width     (DW),
        .output_channel (OC),
        .result_width   (RW),
        .result_length  (RL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_ch    (out_ch),
        .out_row   (out_row),
        .out_col   (out_col)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic frame_t make_frame(input logic [15:0] base);
        frame_t f;
        for (int i = 0; i < NE; i++) f[i*DW +: DW] = base + 16'(i);
        return f;
    endfunction

    // Present a frame for one cycle while the block is idle
    task automatic capture_frame(input logic [15:0] base);
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        result    = make_frame(base);
        out_ready = 1'b0;
    endtask

    // Follow a stream of nfr frames; mode 0 = always ready, 1 = ready 1,0,0,...
    // Optional injection of offered frames starting at cycle inj_at.
    task automatic stream(input logic [15:0] base0, input logic [15:0] base1,
                          input int nfr, input int mode, input int inj_at,
                          input logic [15:0] inj_base, input int inj_len);
        int   e  = 0;
        bit   sf = 1'b0;
        int   fr, ei;
        logic rdy, exp_ir;
        for (int cyc = 0; cyc < 100 && e < nfr*NE; cyc++) begin
            @(negedge clk);
            in_valid = (inj_at >= 0) && (cyc >= inj_at) && (cyc < inj_at + inj_len);
            if (in_valid) result = make_frame((cyc == inj_at) ? inj_base : 16'h00C1);
            fr = e / NE;
            ei = e % NE;
            chk("s_valid", 32'(out_valid), 32'd1);
            chk("s_data",  32'(out_data), 32'((fr == 0) ? base0 : base1) + 32'(ei));
            chk("s_ch",    32'(out_ch),  32'(ei / 4));
            chk("s_row",   32'(out_row), 32'((ei / 2) % 2));
            chk("s_col",   32'(out_col), 32'(ei % 2));
            chk("s_last",  32'(out_last), 32'(ei == NE-1));
            exp_ir = PP ? !sf : 1'b0;
            chk("s_in_ready", 32'(in_ready), 32'(exp_ir));
            rdy = (mode == 0) || (cyc % 3 == 0);
            out_ready = rdy;
            if (rdy && ei == NE-1) sf = 1'b0;
            else if (in_valid && exp_ir) sf = 1'b1;
            if (rdy) e++;
        end
        chk("s_beats", 32'(e), 32'(nfr*NE));
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("s_valid_after", 32'(out_valid), 32'd0);
        chk("s_in_ready_after", 32'(in_ready), 32'd1);
    endtask

    initial begin
        vt[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 0, 0, 0, 1'b1};
        vt[1] = '{1'b1, 1'b1, 16'h0001, 1'b0, 0, 0, 0, PP};
        vt[2] = '{1'b1, 1'b1, 16'h0002, 1'b0, 0, 0, 1, PP};
        vt[3] = '{1'b1, 1'b1, 16'h0003, 1'b0, 0, 1, 0, PP};
        vt[4] = '{1'b1, 1'b1, 16'h0004, 1'b0, 0, 1, 1, PP};
        vt[5] = '{1'b1, 1'b1, 16'h0005, 1'b0, 1, 0, 0, PP};
        vt[6] = '{1'b1, 1'b1, 16'h0006, 1'b0, 1, 0, 1, PP};
        vt[7] = '{1'b1, 1'b1, 16'h0007, 1'b0, 1, 1, 0, PP};
        vt[8] = '{1'b1, 1'b1, 16'h0008, 1'b1, 1, 1, 1, PP};
        vt[9] = '{1'b0, 1'b0, 16'h0000, 1'b0, 0, 0, 0, 1'b1};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid",    32'(out_valid), 32'd0);
        chk("rst_data",     32'(out_data),  32'd0);
        chk("rst_last",     32'(out_last),  32'd0);
        chk("rst_coord",    32'({out_ch, out_row, out_col}), 32'd0);
        chk("rst_in_ready", 32'(in_ready),  32'd1);
        reset = 1'b1;

        // Single frame, table driven, always ready
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            chk("t_valid",    32'(out_valid), 32'(vt[k].vld));
            chk("t_last",     32'(out_last),  32'(vt[k].last));
            chk("t_in_ready", 32'(in_ready),  32'(vt[k].irdy));
            if (vt[k].vld) begin
                chk("t_data", 32'(out_data), 32'(vt[k].data));
                chk("t_ch",   32'(out_ch),   32'(vt[k].ch));
                chk("t_row",  32'(out_row),  32'(vt[k].row));
                chk("t_col",  32'(out_col),  32'(vt[k].col));
            end
            in_valid  = (k == 0);
            if (k == 0) result = make_frame(16'h0001);
            out_ready = vt[k].rdy;
        end

        // Stalling downstream: elements hold, exactly 8 beats
        capture_frame(16'h0011);
        stream(16'h0011, 16'h0000, 1, 1, -1, 16'h0000, 0);

`ifndef CONV_STREAM_PINGPONG_EN
        // Frame offered mid-stream is ignored
        capture_frame(16'h0001);
        stream(16'h0001, 16'h0000, 1, 0, 3, 16'h00A1, 2);
`endif

        // Asynchronous reset after the third beat
        capture_frame(16'h0021);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            chk("r_data", 32'(out_data), 32'h21 + 32'(k));
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk("r_data4", 32'(out_data), 32'h24);
        reset = 1'b0;
        #1;
        chk("r_async_valid", 32'(out_valid), 32'd0);
        chk("r_async_data",  32'(out_data),  32'd0);
        chk("r_async_last",  32'(out_last),  32'd0);
        chk("r_async_coord", 32'({out_ch, out_row, out_col}), 32'd0);
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("r_post_valid",    32'(out_valid), 32'd0);
        chk("r_post_in_ready", 32'(in_ready),  32'd1);
        capture_frame(16'h0031);
        stream(16'h0031, 16'h0000, 1, 0, -1, 16'h0000, 0);

`ifdef CONV_STREAM_PINGPONG_EN
        // Second frame captured mid-stream, third frame refused while shadow full
        capture_frame(16'h0001);
        stream(16'h0001, 16'h00B1, 2, 0, 2, 16'h00B1, 4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
